// File: rtl/os_lane_aligner_pkg.sv
// Shared types and symbol constants for the ordered-set lane aligner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package os_pkg;

  localparam logic [7:0] COM     = 8'hBC;
  localparam logic [7:0] SKP_SYM = 8'h1C;
  localparam logic [7:0] IDL     = 8'h7C;
  localparam logic [7:0] TS1_ID  = 8'h4A;
  localparam logic [7:0] TS2_ID  = 8'h45;
  localparam logic [7:0] G3_TS1  = 8'h1E;
  localparam logic [7:0] G3_TS2  = 8'h2D;
  localparam logic [7:0] G3_SKP  = 8'hAA;
  localparam logic [7:0] G3_EIOS = 8'h66;

  localparam int LANE_MASK_W = 16;

  typedef enum logic [2:0] {
    OS_NONE    = 3'd0,
    OS_TS1     = 3'd1,
    OS_TS2     = 3'd2,
    OS_SKP     = 3'd3,
    OS_EIOS    = 3'd4,
    OS_UNKNOWN = 3'd7
  } os_type_t;

  typedef enum logic {
    ST_HUNT,
    ST_COLLECT
  } os_state_t;

  function automatic logic [LANE_MASK_W-1:0] lanes_active(input logic [4:0] num_lanes);
    case (num_lanes)
      5'd2:    return 16'h0003;
      5'd4:    return 16'h000F;
      5'd8:    return 16'h00FF;
      5'd16:   return 16'hFFFF;
      default: return 16'h0001;
    endcase
  endfunction

  function automatic logic is_start(input logic [7:0] sym, input logic g3);
    if (g3)
      return (sym == G3_TS1) || (sym == G3_TS2) || (sym == G3_SKP) || (sym == G3_EIOS);
    return sym == COM;
  endfunction

  function automatic os_type_t g3_type(input logic [7:0] sym);
    case (sym)
      G3_TS1:  return OS_TS1;
      G3_TS2:  return OS_TS2;
      G3_SKP:  return OS_SKP;
      G3_EIOS: return OS_EIOS;
      default: return OS_UNKNOWN;
    endcase
  endfunction

endpackage

// File: rtl/os_lane_aligner_collector.sv
// One lane: hunt for an ordered-set start, accumulate, classify (OS_ERR_CNT_EN adds err_cnt).
// Latency: os_valid one cycle after the cycle carrying the last symbol.
// Backpressure: none; valid_in=0 freezes the collector.
module os_lane_collector
  import os_pkg::*;
#(
  parameter int SYMS_PER_CLK = 4,
  parameter int OS_LEN       = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2:0]                gen,
  input  logic                      active,
  input  logic                      abort,
  input  logic                      valid_in,
  input  logic [SYMS_PER_CLK*8-1:0] syms,
  output logic                      set_done,
  output logic [2:0]                set_type,
  output logic                      os_valid,
  output logic [2:0]                os_type,
  output logic [4:0]                os_len,
  output logic [OS_LEN*8-1:0]       os_data
`ifdef OS_ERR_CNT_EN
  , output logic [7:0]              err_cnt
`endif
);

  localparam int IW = $clog2(OS_LEN);

  os_state_t            st_q, st_n;
  logic [4:0]           cnt_q, cnt_n, len_q, len_n;
  os_type_t             type_q, type_n, hit_type;
  logic [OS_LEN*8-1:0]  sbuf_q, sbuf_n, hit_buf;
  logic [4:0]           hit_len;
  logic                 hit;
  logic [7:0]           sym;
  logic                 g3;

  assign g3 = (gen >= 3'd3);

  // Symbols are walked oldest-first so a set ending mid-cycle lets the rest restart the hunt.
  always_comb begin
    st_n     = st_q;
    cnt_n    = cnt_q;
    len_n    = len_q;
    type_n   = type_q;
    sbuf_n   = sbuf_q;
    hit      = 1'b0;
    hit_type = OS_NONE;
    hit_len  = '0;
    hit_buf  = '0;
    sym      = '0;
    for (int s = 0; s < SYMS_PER_CLK; s++) begin
      sym = syms[s*8 +: 8];
      if (st_n == ST_HUNT) begin
        if (is_start(sym, g3)) begin
          sbuf_n      = '0;
          sbuf_n[7:0] = sym;
          cnt_n       = 5'd1;
          len_n       = 5'd16;
          type_n      = g3 ? g3_type(sym) : OS_UNKNOWN;
          st_n        = ST_COLLECT;
        end
      end else begin
        sbuf_n[cnt_n[IW-1:0]*8 +: 8] = sym;
        if (!g3 && cnt_n == 5'd1) begin
          if (sym == SKP_SYM) begin
            len_n  = 5'd4;
            type_n = OS_SKP;
          end else if (sym == IDL) begin
            len_n  = 5'd4;
            type_n = OS_EIOS;
          end
        end
        if (!g3 && cnt_n == 5'd6 && len_n == 5'd16)
          type_n = (sym == TS1_ID) ? OS_TS1 : (sym == TS2_ID) ? OS_TS2 : OS_UNKNOWN;
        cnt_n = cnt_n + 5'd1;
        if (cnt_n == len_n) begin
          hit      = 1'b1;
          hit_type = type_n;
          hit_len  = len_n;
          hit_buf  = sbuf_n;
          st_n     = ST_HUNT;
          cnt_n    = '0;
        end
      end
    end
  end

  assign set_done = hit && valid_in && active && !abort;
  assign set_type = hit_type;

  always_ff @(posedge clk) begin
    if (reset || !active) begin
      st_q     <= ST_HUNT;
      cnt_q    <= '0;
      len_q    <= '0;
      type_q   <= OS_NONE;
      sbuf_q   <= '0;
      os_valid <= 1'b0;
      os_type  <= '0;
      os_len   <= '0;
      os_data  <= '0;
`ifdef OS_ERR_CNT_EN
      err_cnt  <= '0;
`endif
    end else if (abort) begin
      st_q     <= ST_HUNT;
      cnt_q    <= '0;
      os_valid <= 1'b0;
`ifdef OS_ERR_CNT_EN
      if (st_q == ST_COLLECT && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
`endif
    end else if (valid_in) begin
      st_q     <= st_n;
      cnt_q    <= cnt_n;
      len_q    <= len_n;
      type_q   <= type_n;
      sbuf_q   <= sbuf_n;
      os_valid <= hit;
      if (hit) begin
        os_type <= hit_type;
        os_len  <= hit_len;
        os_data <= hit_buf;
`ifdef OS_ERR_CNT_EN
        if (hit_type == OS_UNKNOWN && err_cnt != 8'hFF)
          err_cnt <= err_cnt + 8'd1;
`endif
      end
    end else begin
      os_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/os_lane_aligner.sv
// Per-lane ordered-set collectors plus cross-lane agreement (OS_ERR_CNT_EN adds os_err_cnt).
// Latency: os_valid/lanes_agree one cycle after the cycle carrying the last symbol.
// Backpressure: none; valid_in=0 stalls all collectors, rate/width change aborts them.
module os_lane_aligner
  import os_pkg::*;
#(
  parameter int MAX_LANES    = 16,
  parameter int SYMS_PER_CLK = 4,
  parameter int OS_LEN       = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [2:0]                          gen,
  input  logic [4:0]                          num_lanes,
  input  logic                                valid_in,
  input  logic [MAX_LANES*SYMS_PER_CLK*8-1:0] data_in,
  output logic [MAX_LANES-1:0]                os_valid,
  output logic [MAX_LANES*3-1:0]              os_type,
  output logic [MAX_LANES*5-1:0]              os_len,
  output logic [MAX_LANES*OS_LEN*8-1:0]       os_data,
  output logic                                lanes_agree
`ifdef OS_ERR_CNT_EN
  , output logic [MAX_LANES*8-1:0]            os_err_cnt
`endif
);

  logic [2:0]                 gen_q;
  logic [4:0]                 num_lanes_q;
  logic                       abort;
  logic [LANE_MASK_W-1:0]     mask;
  logic [MAX_LANES-1:0]       active;
  logic [MAX_LANES-1:0]       set_done;
  logic [2:0]                 set_type [MAX_LANES];
  logic [SYMS_PER_CLK*8-1:0]  lane_syms [MAX_LANES];
  logic                       agree_n;

  // Sampled during reset too, so the first cycle after reset never looks like a change.
  always_ff @(posedge clk) begin
    gen_q       <= gen;
    num_lanes_q <= num_lanes;
  end

  assign abort = (gen != gen_q) || (num_lanes != num_lanes_q);
  assign mask  = lanes_active(num_lanes);

  for (genvar l = 0; l < MAX_LANES; l++) begin : g_lane
    if (l < LANE_MASK_W) begin : g_act
      assign active[l] = mask[l];
    end else begin : g_off
      assign active[l] = 1'b0;
    end

    for (genvar s = 0; s < SYMS_PER_CLK; s++) begin : g_sym
      assign lane_syms[l][s*8 +: 8] = data_in[(s*MAX_LANES+l)*8 +: 8];
    end

    os_lane_collector #(
      .SYMS_PER_CLK (SYMS_PER_CLK),
      .OS_LEN       (OS_LEN)
    ) u_col (
      .clk      (clk),
      .reset    (reset),
      .gen      (gen),
      .active   (active[l]),
      .abort    (abort),
      .valid_in (valid_in),
      .syms     (lane_syms[l]),
      .set_done (set_done[l]),
      .set_type (set_type[l]),
      .os_valid (os_valid[l]),
      .os_type  (os_type[l*3 +: 3]),
      .os_len   (os_len[l*5 +: 5]),
      .os_data  (os_data[l*OS_LEN*8 +: OS_LEN*8])
`ifdef OS_ERR_CNT_EN
      , .err_cnt (os_err_cnt[l*8 +: 8])
`endif
    );
  end

  // Lane 0 is always active, so agreement implies at least one completed set.
  always_comb begin
    agree_n = 1'b1;
    for (int l = 0; l < MAX_LANES; l++)
      if (active[l] && (!set_done[l] || set_type[l] != set_type[0]))
        agree_n = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset)
      lanes_agree <= 1'b0;
    else
      lanes_agree <= agree_n;
  end

endmodule

// File: tb/tb_os_lane_aligner.sv
// Directed bench for os_lane_aligner; checks os_err_cnt when OS_ERR_CNT_EN is defined.
module tb_os_lane_aligner;

  localparam int ML = 16;
  localparam int SP = 4;
  localparam int OL = 16;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [2:0]            gen;
  logic [4:0]            num_lanes;
  logic                  valid_in;
  logic [ML*SP*8-1:0]    data_in;
  logic [ML-1:0]         os_valid;
  logic [ML*3-1:0]       os_type;
  logic [ML*5-1:0]       os_len;
  logic [ML*OL*8-1:0]    os_data;
  logic                  lanes_agree;
`ifdef OS_ERR_CNT_EN
  logic [ML*8-1:0]       os_err_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  os_lane_aligner #(.MAX_LANES(ML), .SYMS_PER_CLK(SP), .OS_LEN(OL)) dut (
    .clk         (clk),
    .reset       (reset),
    .gen         (gen),
    .num_lanes   (num_lanes),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .os_valid    (os_valid),
    .os_type     (os_type),
    .os_len      (os_len),
    .os_data     (os_data),
    .lanes_agree (lanes_agree)
`ifdef OS_ERR_CNT_EN
    , .os_err_cnt (os_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Four symbols for one lane; w[7:0] is the oldest.
  task automatic put(input int l, input logic [31:0] w);
    for (int s = 0; s < SP; s++)
      data_in[(s*ML+l)*8 +: 8] = w[s*8 +: 8];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] osym(input int l, input int k);
    return os_data[(l*OL+k)*8 +: 8];
  endfunction

  function automatic logic [2:0] otype(input int l);
    return os_type[l*3 +: 3];
  endfunction

  function automatic logic [4:0] olen(input int l);
    return os_len[l*5 +: 5];
  endfunction

  initial begin
    reset = 1'b1; gen = 3'd1; num_lanes = 5'd2; valid_in = 1'b0; data_in = '0;
    tick(); tick();
    check("rst_valid", os_valid, 0);
    check("rst_type", os_type[31:0], 0);
    check("rst_len", os_len[31:0], 0);
    check("rst_data", {31'd0, |os_data}, 0);
    check("rst_agree", lanes_agree, 0);
    reset = 1'b0;

    // Gen1 TS1 on lanes 0 and 1
    valid_in = 1'b1;
    put(0, 32'h10F7F7BC); put(1, 32'h10F7F7BC); tick();
    put(0, 32'h4A4A0002); put(1, 32'h4A4A0002); tick();
    put(0, 32'h4A4A4A4A); put(1, 32'h4A4A4A4A); tick();
    check("ts1_early", os_valid, 0);
    tick();
    check("ts1_valid", os_valid, 16'h0003);
    check("ts1_type0", otype(0), 1);
    check("ts1_type1", otype(1), 1);
    check("ts1_len", olen(0), 16);
    check("ts1_agree", lanes_agree, 1);
    check("ts1_sym0", osym(1, 0), 8'hBC);
    check("ts1_sym6", osym(0, 6), 8'h4A);
    valid_in = 1'b0; tick();
    check("hold_valid", os_valid, 0);
    check("hold_type", otype(0), 1);

    // Gen1 SKP then TS2 back-to-back on lane 0
    valid_in = 1'b1; put(1, 32'h0);
    put(0, 32'h1C1CBC00); tick();
    put(0, 32'hF7F7BC1C); tick();
    check("skp_valid", os_valid, 16'h0001);
    check("skp_type", otype(0), 3);
    check("skp_len", olen(0), 4);
    check("skp_sym3", osym(0, 3), 8'h1C);
    check("skp_sym4", osym(0, 4), 8'h00);
    check("skp_agree", lanes_agree, 0);
    put(0, 32'h45000210); tick();
    put(0, 32'h45454545); tick();
    tick();
    check("ts2_early", os_valid, 0);
    put(0, 32'h00000045); tick();
    check("ts2_valid", os_valid, 16'h0001);
    check("ts2_type", otype(0), 2);
    check("ts2_len", olen(0), 16);
    check("ts2_sym0", osym(0, 0), 8'hBC);
    check("ts2_sym3", osym(0, 3), 8'h10);
    check("ts2_sym15", osym(0, 15), 8'h45);

    // Gen3 x4, start on slot 2
    gen = 3'd3; num_lanes = 5'd4; valid_in = 1'b0; put(0, 32'h0); tick();
    valid_in = 1'b1;
    put(0, 32'h012D0000); tick();
    put(0, 32'h05040302); tick();
    put(0, 32'h09080706); tick();
    put(0, 32'h0D0C0B0A); tick();
    check("g3_early", os_valid, 0);
    put(0, 32'h00000F0E); tick();
    check("g3_valid", os_valid, 16'h0001);
    check("g3_type", otype(0), 2);
    check("g3_len", olen(0), 16);
    check("g3_sym0", osym(0, 0), 8'h2D);
    check("g3_sym1", osym(0, 1), 8'h01);
    check("g3_sym15", osym(0, 15), 8'h0F);

    // Rate change mid-set aborts without a pulse
    gen = 3'd1; valid_in = 1'b0; put(0, 32'h0); tick();
    valid_in = 1'b1;
    put(0, 32'h10F7F7BC); tick();
    put(0, 32'h4A4A0002); tick();
    gen = 3'd3; put(0, 32'h4A4A4A4A); tick();
    check("abort_v0", os_valid, 0);
    tick();
    check("abort_v1", os_valid, 0);
`ifdef OS_ERR_CNT_EN
    check("abort_errcnt", os_err_cnt[7:0], 1);
`endif

    // valid_in gap mid-set
    put(0, 32'h1312111E); tick();
    valid_in = 1'b0; put(0, 32'hAAAAAAAA);
    tick(); tick(); tick();
    check("gap_valid", os_valid, 0);
    valid_in = 1'b1;
    put(0, 32'h17161514); tick();
    put(0, 32'h1B1A1918); tick();
    put(0, 32'h1F1E1D1C); tick();
    check("gap_done", os_valid, 16'h0001);
    check("gap_type", otype(0), 1);
    check("gap_sym0", osym(0, 0), 8'h1E);
    check("gap_sym4", osym(0, 4), 8'h14);
    check("gap_sym15", osym(0, 15), 8'h1F);

    // Reset mid-set drops the partial set
    put(0, 32'h0302011E); tick();
    put(0, 32'h07060504); tick();
    reset = 1'b1; put(0, 32'h0B0A0908); tick();
    reset = 1'b0;
    check("mrst_valid", os_valid, 0);
    check("mrst_type", otype(0), 0);
    check("mrst_len", olen(0), 0);
    check("mrst_data", {31'd0, |os_data}, 0);
    put(0, 32'h0F0E0D0C); tick();
    check("mrst_nopulse0", os_valid, 0);
    put(0, 32'h13121110); tick();
    check("mrst_nopulse1", os_valid, 0);

    // Illegal width 5 behaves as x1
    num_lanes = 5'd5; valid_in = 1'b0; tick();
    valid_in = 1'b1;
    for (int l = 0; l < ML; l++) put(l, 32'h000000AA);
    tick();
    for (int l = 0; l < ML; l++) put(l, 32'h0);
    tick(); tick(); tick();
    check("x5_valid", os_valid, 16'h0001);
    check("x5_type0", otype(0), 3);
    check("x5_type5", otype(5), 0);
    check("x5_agree", lanes_agree, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
